// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared types and constants for the SD command-line engine.
//   - state_t    : engine states
//   - RSP_*      : response-type encodings on rsp_type
//   - TOKEN_LEN_*: on-wire token lengths
//   - CRC7_POLY  : x^7 + x^3 + 1
//   - crc7_step  : one MSB-first CRC7 update
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX       = 3'd1,
    TURN     = 3'd2,
    WAIT_RSP = 3'd3,
    RX       = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_48   = 2'b01;
  localparam logic [1:0] RSP_136  = 2'b10;

  localparam int TOKEN_LEN_SHORT = 48;
  localparam int TOKEN_LEN_LONG  = 136;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_serial_host_if.sv
// sd_cmd_serial_host_if: host-side command bus of the SD command-line engine.
//   master: host (drives start, cmd_index, cmd_arg, rsp_type)
//   slave : engine (drives busy, done, rsp, timeout_err, crc_err)
interface sd_cmd_serial_host_if;
  logic         start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   rsp_type;
  logic         busy;
  logic         done;
  logic [127:0] rsp;
  logic         timeout_err;
  logic         crc_err;

  modport master (
    output start, cmd_index, cmd_arg, rsp_type,
    input  busy, done, rsp, timeout_err, crc_err
  );

  modport slave (
    input  start, cmd_index, cmd_arg, rsp_type,
    output busy, done, rsp, timeout_err, crc_err
  );
endinterface

// File: rtl/sd_crc7_serial.sv
// sd_crc7_serial: bit-serial CRC7 (x^7 + x^3 + 1), MSB first.
//   clk, rst_n : SD clock, async active-low reset
//   clear      : synchronous clear to zero (wins over enable)
//   enable     : fold bit_in into the CRC this cycle
//   crc[6:0]   : current remainder
module sd_crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= crc7_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_cmd_serial_host.sv
// sd_cmd_serial_host: SD CMD-line engine on SD_CLK. Sends a 48-bit command
// token with generated CRC7, then optionally captures a 48/136-bit response.
//   clk, rst_n : SD_CLK from the divider, async active-low reset
//   host       : sd_cmd_serial_host_if.slave (request fields, status, rsp)
//   cmd_in     : CMD pad input
//   cmd_out    : CMD pad output value
//   cmd_oe     : CMD pad output enable
// Parameters: TIMEOUT (response start-bit wait), NCR_MIN (turnaround cycles).
// Build option: SD_RSP_CRC_CHECK_EN adds response CRC7 checking; without it
// crc_err is tied to 0.
//
// state    | meaning
// IDLE     | waiting for start
// TX       | driving the 48 token bits, cmd_out holds bit tx_cnt
// TURN     | line released for NCR_MIN cycles
// WAIT_RSP | looking for the response start bit
// RX       | shifting in the rest of the response
// DONE     | one-cycle done pulse, busy already low
module sd_cmd_serial_host
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int NCR_MIN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sd_cmd_serial_host_if.slave  host,
  input  logic                 cmd_in,
  output logic                 cmd_out,
  output logic                 cmd_oe
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam int TURN_W = $clog2(NCR_MIN) + 1;

  state_t              state;
  logic [5:0]          tx_cnt;
  logic [5:0]          tx_next;
  logic [38:0]         tx_sr;
  logic [1:0]          rsp_type_q;
  logic [TURN_W-1:0]   turn_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [7:0]          rx_cnt;
  logic [6:0]          tx_crc;
  logic                tx_crc_clr;
  logic                tx_crc_en;
  logic                rsp_expected;

  assign tx_next      = tx_cnt - 6'd1;
  assign rsp_expected = (rsp_type_q == RSP_48) || (rsp_type_q == RSP_136);

  // The start bit (always 0) is not folded in: a zero bit on a cleared CRC
  // leaves it at zero, so feeding only bits 46..8 gives the same result.
  assign tx_crc_clr = (state == IDLE);
  assign tx_crc_en  = (state == TX) && (tx_cnt != 6'd0) && (tx_next >= 6'd8);

  sd_crc7_serial u_tx_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tx_crc_clr),
    .enable (tx_crc_en),
    .bit_in (tx_sr[38]),
    .crc    (tx_crc)
  );

`ifdef SD_RSP_CRC_CHECK_EN
  // rx_cnt equals the token bit index being sampled, so one window covers
  // both lengths (bits 47..8 or 127..8, start bit skipped as on TX).
  logic [6:0] rx_crc;
  logic       rx_crc_en;

  assign rx_crc_en = (state == RX) && (rx_cnt >= 8'd8) && (rx_cnt <= 8'd127);

  sd_crc7_serial u_rx_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tx_crc_clr),
    .enable (rx_crc_en),
    .bit_in (cmd_in),
    .crc    (rx_crc)
  );
`else
  assign host.crc_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cmd_out          <= 1'b1;
      cmd_oe           <= 1'b0;
      host.busy        <= 1'b0;
      host.done        <= 1'b0;
      host.rsp         <= '0;
      host.timeout_err <= 1'b0;
`ifdef SD_RSP_CRC_CHECK_EN
      host.crc_err     <= 1'b0;
`endif
      tx_cnt           <= '0;
      tx_sr            <= '0;
      rsp_type_q       <= RSP_NONE;
      turn_cnt         <= '0;
      wait_cnt         <= '0;
      rx_cnt           <= '0;
    end else begin
      host.done <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            tx_sr            <= {1'b1, host.cmd_index, host.cmd_arg};
            rsp_type_q       <= host.rsp_type;
            host.rsp         <= '0;
            host.timeout_err <= 1'b0;
`ifdef SD_RSP_CRC_CHECK_EN
            host.crc_err     <= 1'b0;
`endif
            cmd_out          <= 1'b0;
            cmd_oe           <= 1'b1;
            host.busy        <= 1'b1;
            tx_cnt           <= 6'd47;
            state            <= TX;
          end
        end

        TX: begin
          if (tx_cnt == 6'd0) begin
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
            if (rsp_expected) begin
              turn_cnt <= TURN_W'(NCR_MIN - 1);
              state    <= TURN;
            end else begin
              host.done <= 1'b1;
              host.busy <= 1'b0;
              state     <= DONE;
            end
          end else begin
            tx_cnt <= tx_next;
            if (tx_next >= 6'd8) begin
              cmd_out <= tx_sr[38];
              tx_sr   <= {tx_sr[37:0], 1'b0};
            end else if (tx_next != 6'd0) begin
              cmd_out <= tx_crc[3'(tx_next - 6'd1)];
            end else begin
              cmd_out <= 1'b1;
            end
          end
        end

        TURN: begin
          if (turn_cnt == '0) begin
            wait_cnt <= '0;
            state    <= WAIT_RSP;
          end else begin
            turn_cnt <= turn_cnt - TURN_W'(1);
          end
        end

        WAIT_RSP: begin
          if (!cmd_in) begin
            rx_cnt <= (rsp_type_q == RSP_136) ? 8'(TOKEN_LEN_LONG - 2)
                                              : 8'(TOKEN_LEN_SHORT - 2);
            state  <= RX;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            host.timeout_err <= 1'b1;
            host.done        <= 1'b1;
            host.busy        <= 1'b0;
            state            <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        RX: begin
          host.rsp <= {host.rsp[126:0], cmd_in};
          if (rx_cnt == 8'd0) begin
`ifdef SD_RSP_CRC_CHECK_EN
            // rsp[6:0] already holds token bits 7..1; this cycle samples the end bit.
            host.crc_err <= (rx_crc != host.rsp[6:0]);
`endif
            host.done <= 1'b1;
            host.busy <= 1'b0;
            state     <= DONE;
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
module tb_sd_cmd_serial_host;
  import sd_cmd_pkg::*;

  logic clk;
  logic rst_n;
  logic cmd_in;
  logic cmd_out;
  logic cmd_oe;

  sd_cmd_serial_host_if bus ();

  sd_cmd_serial_host #(.TIMEOUT(64), .NCR_MIN(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (bus),
    .cmd_in  (cmd_in),
    .cmd_out (cmd_out),
    .cmd_oe  (cmd_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] rsp;
    logic         to;
    logic         ce;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic tx_q[$];
  exp_t res_q[$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7_ref(input logic [135:0] v, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = hi; i >= lo; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_token(input logic [5:0] idx, input logic [31:0] arg);
    logic [135:0] v;
    v        = '0;
    v[47:8]  = {2'b01, idx, arg};
    v[7:1]   = crc7_ref(v, 47, 8);
    v[0]     = 1'b1;
    return v[47:0];
  endfunction

  function automatic logic [135:0] make_r2(input logic [119:0] body);
    logic [135:0] v;
    v           = '0;
    v[135:128]  = 8'h3F;
    v[127:8]    = body;
    v[7:1]      = crc7_ref(v, 127, 8);
    v[0]        = 1'b1;
    return v;
  endfunction

  // Line monitor: every driven bit is matched against the scoreboard, and
  // every done pulse pops one expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (cmd_oe) begin
        if (tx_q.size() == 0) check_val("tx_extra_bit", 128'(cmd_oe), 128'(0));
        else check_val("tx_bit", 128'(cmd_out), 128'(tx_q.pop_front()));
      end
      if (bus.done) begin
        done_cnt++;
        if (res_q.size() == 0) begin
          check_val("done_extra", 128'(bus.done), 128'(0));
        end else begin
          e = res_q.pop_front();
          check_val("rsp", bus.rsp, e.rsp);
          check_val("timeout_err", 128'(bus.timeout_err), 128'(e.to));
          check_val("crc_err", 128'(bus.crc_err), 128'(e.ce));
          check_val("busy_at_done", 128'(bus.busy), 128'(0));
          check_val("oe_at_done", 128'(cmd_oe), 128'(0));
        end
      end
    end
  end

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic [47:0] tok, input bit send_rsp, input logic [135:0] rsp_tok,
                         input int rsp_len, input int delay, input int glitch_cyc, input int exp_lat,
                         input logic [127:0] exp_rsp, input logic exp_to, input logic exp_ce);
    exp_t e;
    int   cyc;
    int   turn_seen;
    int   bit_i;
    int   done0;
    for (int i = 47; i >= 0; i--) tx_q.push_back(tok[i]);
    e.rsp = exp_rsp;
    e.to  = exp_to;
    e.ce  = exp_ce;
    res_q.push_back(e);
    done0 = done_cnt;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.rsp_type  = rt;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.cmd_index = ~idx;
    bus.cmd_arg   = ~arg;
    bus.rsp_type  = ~rt;
    cyc = 1;
    check_val("busy_after_start", 128'(bus.busy), 128'(1));
    turn_seen = -1;
    bit_i     = rsp_len - 1;
    while (!bus.done && cyc < 400) begin
      if (turn_seen < 0 && !cmd_oe) turn_seen = cyc;
      bus.start = (cyc == glitch_cyc);
      if (send_rsp && turn_seen >= 0 && cyc >= turn_seen + delay && bit_i >= 0) begin
        cmd_in = rsp_tok[bit_i];
        bit_i--;
      end else begin
        cmd_in = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 400) check_val("done_wait_expired", 128'(0), 128'(1));
    check_val("done_latency", 128'(cyc), 128'(exp_lat));
    cmd_in    = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check_val("done_one_cycle", 128'(bus.done), 128'(0));
    check_val("busy_after_done", 128'(bus.busy), 128'(0));
    @(negedge clk);
    check_val("done_count", 128'(done_cnt - done0), 128'(1));
    check_val("tx_q_drained", 128'(tx_q.size()), 128'(0));
    check_val("res_q_drained", 128'(res_q.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [135:0] rsp8;
    logic [135:0] rsp_bad;
    logic [135:0] r2;
    logic [127:0] rnd;
    logic [47:0]  tok;
    logic         exp_bad_crc;
    logic [5:0]   ridx;
    logic [31:0]  rarg;
    int           d;

    rst_n         = 1'b0;
    cmd_in        = 1'b1;
    bus.start     = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;
    bus.rsp_type  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_cmd_out", 128'(cmd_out), 128'(1));
    check_val("rst_cmd_oe", 128'(cmd_oe), 128'(0));
    check_val("rst_busy", 128'(bus.busy), 128'(0));
    check_val("rst_done", 128'(bus.done), 128'(0));
    check_val("rst_rsp", bus.rsp, 128'(0));
    check_val("rst_timeout", 128'(bus.timeout_err), 128'(0));
    check_val("rst_crc_err", 128'(bus.crc_err), 128'(0));
    rst_n = 1'b1;

    // CMD0, no response
    run_cmd(6'd0, 32'h0, 2'b00, 48'h400000000095, 1'b0, '0, 0, 0, -1, 49, '0, 1'b0, 1'b0);

    // CMD8 with a good R7-style response
    rsp8 = {88'h0, 48'h48000001AA87};
    run_cmd(6'd8, 32'h000001AA, 2'b01, 48'h48000001AA87, 1'b1, rsp8, 48, 5, -1, 102,
            128'(rsp8[46:0]), 1'b0, 1'b0);

    // same response with token bit 20 flipped
    rsp_bad = rsp8 ^ (136'd1 << 20);
`ifdef SD_RSP_CRC_CHECK_EN
    exp_bad_crc = 1'b1;
`else
    exp_bad_crc = 1'b0;
`endif
    run_cmd(6'd8, 32'h000001AA, 2'b01, 48'h48000001AA87, 1'b1, rsp_bad, 48, 5, -1, 102,
            128'(rsp_bad[46:0]), 1'b0, exp_bad_crc);

    // no start bit: timeout after 2 turnaround + 64 wait cycles, rsp cleared
    run_cmd(6'd55, 32'h0, 2'b01, make_token(6'd55, 32'h0), 1'b0, '0, 0, 0, -1, 115,
            '0, 1'b1, 1'b0);

    // start bit on the last allowed wait sample is still accepted
    run_cmd(6'd8, 32'h000001AA, 2'b01, 48'h48000001AA87, 1'b1, rsp8, 48, 65, -1, 162,
            128'(rsp8[46:0]), 1'b0, 1'b0);

    // start bit on the very first wait sample
    run_cmd(6'd8, 32'h000001AA, 2'b01, 48'h48000001AA87, 1'b1, rsp8, 48, 2, -1, 99,
            128'(rsp8[46:0]), 1'b0, 1'b0);

    // rsp_type 11 behaves as no response
    run_cmd(6'd7, 32'hA5A5_0F0F, 2'b11, make_token(6'd7, 32'hA5A5_0F0F), 1'b0, '0, 0, 0, -1, 49,
            '0, 1'b0, 1'b0);

    // START pulsed while TX bit 10 is on the line is ignored
    run_cmd(6'd13, 32'hDEADBEEF, 2'b00, make_token(6'd13, 32'hDEADBEEF), 1'b0, '0, 0, 0, 38, 49,
            '0, 1'b0, 1'b0);

    // 136-bit response
    rnd = {$urandom, $urandom, $urandom, $urandom};
    r2  = make_r2(rnd[119:0]);
    run_cmd(6'd2, 32'h0, 2'b10, make_token(6'd2, 32'h0), 1'b1, r2, 136, 5, -1, 190,
            r2[127:0], 1'b0, 1'b0);

    // random 48-bit commands and responses
    for (int k = 0; k < 3; k++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      d    = int'($urandom_range(2, 20));
      rsp8 = {88'h0, make_token(6'($urandom_range(0, 63)), $urandom)};
      run_cmd(ridx, rarg, 2'b01, make_token(ridx, rarg), 1'b1, rsp8, 48, d, -1, 97 + d,
              128'(rsp8[46:0]), 1'b0, 1'b0);
    end

    // reset while TX bit 20 is on the line, then a fresh command
    tok = make_token(6'd17, 32'h12345678);
    for (int i = 47; i >= 0; i--) tx_q.push_back(tok[i]);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.cmd_index = 6'd17;
    bus.cmd_arg   = 32'h12345678;
    bus.rsp_type  = 2'b01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (27) @(negedge clk);
    check_val("pre_reset_oe", 128'(cmd_oe), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_oe", 128'(cmd_oe), 128'(0));
    check_val("async_rst_cmd_out", 128'(cmd_out), 128'(1));
    check_val("async_rst_busy", 128'(bus.busy), 128'(0));
    tx_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_cmd(6'd17, 32'h12345678, 2'b00, tok, 1'b0, '0, 0, 0, -1, 49, '0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
